fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the Synchronous_FIFO. It drains the FIFO one word at a time using the FIFO's rd_en/data_out/FIFO_empty interface and serialises each word as an asynchronous UART frame on a single output line.
- Transmit order: start bit, data LSB-first, optional parity bit, stop bit(s).
- Sits between the FIFO and the chip-level serial pin; idles high.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO's DATA_WIDTH.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_en  input  1  permission to start new frames; sampled only at frame boundaries.
- fifo_data_out  input  DATA_WIDTH  FIFO read data; valid on the cycle after the FIFO samples rd_en.
- fifo_empty  input  1  FIFO_empty from the FIFO.
- fifo_rd_en  output  1  read strobe to the FIFO; one cycle per word.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  high whenever state is not IDLE.
- frame_done  output  1  one-cycle pulse after the last stop bit of each frame.
- frame_count  output  16  frames sent since reset; wraps from 0xFFFF to 0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, frame_count=0, baud counter=0, bit index=0, shift register=0.
- All outputs are registered or decoded from state only (Moore); no combinational path from any input to any output.
- State sequence: IDLE -> READ -> WAIT -> START -> DATA -> [PARITY] -> STOP -> IDLE/READ.
- IDLE: if tx_en=1 and fifo_empty=0 at the edge, go to READ; otherwise stay. tx=1.
- READ: exactly one cycle, with fifo_rd_en=1 (fifo_rd_en = state==READ). Always advances to WAIT.
- WAIT: one cycle while the FIFO updates data_out. At the exiting edge: load fifo_data_out into the shift register, compute the parity bit, set tx=0, go to START.
- Latency: the edge that leaves IDLE is E0; tx falls after E2.
- START, DATA, PARITY and each STOP bit hold tx for exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1. The counter clears on every bit transition.
- DATA: DATA_WIDTH bits, LSB first; the shift register shifts right and the bit index counts 0..DATA_WIDTH-1.
- PARITY (only when PARITY_EN=1): parity bit = XOR of the data bits, XOR PARITY_ODD.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end: pulse frame_done, increment frame_count.
  - If tx_en=1 and fifo_empty=0, go to READ (back-to-back frames with a 2-cycle high gap: READ, WAIT).
  - Otherwise go to IDLE.
- Frame length from the fall of the start bit to the end of the stop bit(s): (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_en deasserted mid-frame: the current frame completes unchanged, then the block idles.
- fifo_empty asserted mid-frame: ignored; it is only evaluated in IDLE and at the end of STOP.
- The block never asserts fifo_rd_en while fifo_empty=1 (evaluated at the deciding edge).
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The word is lost; the FIFO is not re-read.
- frame_done and fifo_rd_en never assert in the same cycle.

Decomposition:
- Package fifo_uart_pkg holds:
  - the state enum (IDLE, READ, WAIT, START, DATA, PARITY, STOP);
  - a function for frame-length calculation;
  - a parity function.
- One natural sub-module: uart_baud_counter. It counts 0..CLKS_PER_BIT-1, takes a clear input, and outputs a bit_tick pulse. The FSM and shift register stay in the top module.

Test Plan:
- Reset, then CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1: FIFO holds 0xA5, tx_en=1 -> fifo_rd_en for 1 cycle; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles); frame_done pulses once; frame_count=1.
- Same word 0xA5 with PARITY_EN=1 -> parity bit 0 when PARITY_ODD=0 and 1 when PARITY_ODD=1; frame is 44 cycles.
- FIFO preloaded with 0x01, 0x02, 0x03, STOP_BITS=2 -> three frames; tx stays high for 8+2 cycles between start bits of consecutive frames; exactly 3 fifo_rd_en pulses; frame_count=3; then busy=0 with fifo_empty=1.
- FIFO empty, tx_en=1 for 100 cycles -> fifo_rd_en stays 0, tx=1, busy=0.
- tx_en dropped during the DATA bits of 0x3C, with 2 words queued -> the 0x3C frame completes; no further fifo_rd_en until tx_en returns.
- rst asserted during bit 3 of a frame -> tx=1, busy=0, frame_count=0 immediately; after rst is released with the FIFO non-empty, a new frame starts with the next word.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Holds the FSM state encoding plus frame-length and parity helpers.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    localparam int unsigned MaxDataWidth = 64;

    // Cycles from the falling edge of the start bit to the end of the last stop bit.
    function automatic int unsigned frame_cycles(
        input int unsigned data_width,
        input int unsigned parity_en,
        input int unsigned stop_bits,
        input int unsigned clks_per_bit
    );
        return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
    endfunction

    function automatic logic parity_bit(
        input logic [MaxDataWidth-1:0] data,
        input logic                    odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, wrapping on its own at the end of each bit.
// i_clear holds it at zero while no bit is being transmitted.
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    output logic        o_bit_tick,
    output logic [15:0] o_count
);

    localparam logic [15:0] LastCount = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == LastCount)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_bit_tick = (r_count == LastCount);
    assign o_count    = r_count;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serialises each word as a UART frame:
// start bit, data LSB first, optional parity bit, one or two stop bits. Line idles high.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);

    localparam int unsigned    IdxW         = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IdxW-1:0] LastBit     = IdxW'(DATA_WIDTH - 1);
    localparam logic [IdxW-1:0] LastStop    = IdxW'(STOP_BITS - 1);
    localparam logic [15:0]     PreLastCount = 16'(CLKS_PER_BIT - 2);

    state_t                r_state;
    logic                  r_tx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic [IdxW-1:0]       r_bit_idx;
    logic                  r_frame_done;
    logic [15:0]           r_frame_count;

    logic        w_start;
    logic        w_baud_clear;
    logic        w_bit_tick;
    logic [15:0] w_baud_count;

    assign w_start      = tx_en && !fifo_empty;
    assign w_baud_clear = (r_state == StIdle) || (r_state == StRead) || (r_state == StWait);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_clear    (w_baud_clear),
        .o_bit_tick (w_bit_tick),
        .o_count    (w_baud_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= StIdle;
            r_tx          <= 1'b1;
            r_shift       <= '0;
            r_parity      <= 1'b0;
            r_bit_idx     <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            // Pulse lands on the final stop-bit cycle so it never overlaps a READ cycle.
            r_frame_done <= (r_state == StStop) && (r_bit_idx == LastStop) &&
                            (w_baud_count == PreLastCount);
            case (r_state)
                StIdle: begin
                    if (w_start) r_state <= StRead;
                end
                StRead: begin
                    r_state <= StWait;
                end
                StWait: begin
                    r_shift  <= fifo_data_out;
                    r_parity <= parity_bit(MaxDataWidth'(fifo_data_out), PARITY_ODD);
                    r_tx     <= 1'b0;
                    r_state  <= StStart;
                end
                StStart: begin
                    if (w_bit_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= StData;
                    end
                end
                StData: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == LastBit) begin
                            r_bit_idx <= '0;
                            if (PARITY_EN) begin
                                r_tx    <= r_parity;
                                r_state <= StParity;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= StStop;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                StParity: begin
                    if (w_bit_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= StStop;
                    end
                end
                StStop: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == LastStop) begin
                            r_bit_idx     <= '0;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_state       <= w_start ? StRead : StIdle;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign fifo_rd_en  = (r_state == StRead);
    assign busy        = (r_state != StIdle);
    assign tx          = r_tx;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four parameter variants run in lockstep, each fed by its own FIFO,
// checked every cycle against a frame-level reference plus hand-computed line patterns.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int NDut      = 4;
    localparam int Cpb       = 4;
    localparam int FifoDepth = 32;

    typedef struct packed {
        logic tx;
        logic rd;
        logic busy;
        logic done;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic [7:0] fdo    [NDut];
    logic       fempty [NDut];
    logic       rd     [NDut];
    logic       txl    [NDut];
    logic       bsy    [NDut];
    logic       done   [NDut];
    logic [15:0] fcnt  [NDut];

    int n_checks = 0;
    int n_errors = 0;

    // Variant 0: no parity, 1 stop. 1: even parity. 2: odd parity. 3: no parity, 2 stops.
    function automatic int pe_of(input int i);  return (i == 1 || i == 2) ? 1 : 0; endfunction
    function automatic int odd_of(input int i); return (i == 2) ? 1 : 0;           endfunction
    function automatic int sb_of(input int i);  return (i == 3) ? 2 : 1;           endfunction

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
                   .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_data_out(fdo[0]), .fifo_empty(fempty[0]),
        .fifo_rd_en(rd[0]), .tx(txl[0]), .busy(bsy[0]), .frame_done(done[0]),
        .frame_count(fcnt[0]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
                   .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_data_out(fdo[1]), .fifo_empty(fempty[1]),
        .fifo_rd_en(rd[1]), .tx(txl[1]), .busy(bsy[1]), .frame_done(done[1]),
        .frame_count(fcnt[1]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1'b1), .PARITY_ODD(1'b1),
                   .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_data_out(fdo[2]), .fifo_empty(fempty[2]),
        .fifo_rd_en(rd[2]), .tx(txl[2]), .busy(bsy[2]), .frame_done(done[2]),
        .frame_count(fcnt[2]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
                   .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_data_out(fdo[3]), .fifo_empty(fempty[3]),
        .fifo_rd_en(rd[3]), .tx(txl[3]), .busy(bsy[3]), .frame_done(done[3]),
        .frame_count(fcnt[3]));

    always #5 clk = ~clk;

    // FIFO models: data_out updates on the edge that samples rd_en.
    logic [7:0] mem [NDut][FifoDepth];
    int wr_ptr [NDut];
    int rd_ptr [NDut];

    for (genvar g = 0; g < NDut; g++) begin : g_fifo
        assign fempty[g] = (wr_ptr[g] == rd_ptr[g]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NDut; i++) begin
            if (rd[i] === 1'b1) begin
                fdo[i]    <= mem[i][rd_ptr[i] % FifoDepth];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    // Reference: expected per-cycle outputs of each in-flight frame, built from the frame rules.
    ent_t       tl   [NDut][$];
    logic [7:0] mq   [NDut][$];
    bit  [15:0] mcnt [NDut];

    task automatic push_frame(input int i, input logic [7:0] w);
        logic [11:0] fb;
        int nb;
        nb = 0;
        fb[nb++] = 1'b0;
        for (int b = 0; b < 8; b++) fb[nb++] = w[b];
        if (pe_of(i) != 0) fb[nb++] = (^w) ^ (odd_of(i) != 0);
        for (int s = 0; s < sb_of(i); s++) fb[nb++] = 1'b1;
        tl[i].push_back(ent_t'(4'b1110));
        tl[i].push_back(ent_t'(4'b1010));
        for (int c = 0; c < nb * Cpb; c++) begin
            tl[i].push_back('{tx: fb[c / Cpb], rd: 1'b0, busy: 1'b1, done: (c == nb * Cpb - 1)});
        end
    endtask

    always @(posedge clk) begin : p_model
        ent_t e;
        for (int i = 0; i < NDut; i++) begin
            if (!rst) begin
                tl[i].delete();
                mcnt[i] = '0;
            end else begin
                if (tl[i].size() > 0) begin
                    e = tl[i].pop_front();
                    if (e.done) mcnt[i] = mcnt[i] + 16'd1;
                end
                if (tl[i].size() == 0 && tx_en && mq[i].size() > 0) begin
                    push_frame(i, mq[i].pop_front());
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : p_compare
        ent_t e;
        for (int i = 0; i < NDut; i++) begin
            e = (rst && tl[i].size() > 0) ? tl[i][0] : ent_t'(4'b1000);
            check($sformatf("cycle_dut%0d", i),
                  32'({txl[i], rd[i], bsy[i], done[i], fcnt[i]}),
                  32'({e, (rst ? 16'(mcnt[i]) : 16'h0)}));
        end
    end

    // Per-cycle line traces for the pattern checks.
    bit trtx [NDut][$];
    bit trrd [NDut][$];
    bit trdn [NDut][$];

    always @(negedge clk) begin
        for (int i = 0; i < NDut; i++) begin
            trtx[i].push_back(txl[i] === 1'b1);
            trrd[i].push_back(rd[i] === 1'b1);
            trdn[i].push_back(done[i] === 1'b1);
        end
    end

    task automatic clear_traces();
        for (int i = 0; i < NDut; i++) begin
            trtx[i].delete();
            trrd[i].delete();
            trdn[i].delete();
        end
    endtask

    function automatic int first_fall(input int i, input int from);
        for (int k = from; k < trtx[i].size(); k++) if (!trtx[i][k]) return k;
        return -1;
    endfunction

    // Line level at the middle of each bit, starting at the first start bit; bit k -> v[k].
    function automatic logic [15:0] frame_bits(input int i, input int nb);
        int f;
        logic [15:0] v;
        f = first_fall(i, 0);
        v = '0;
        if (f < 0) return 16'hFFFF;
        for (int b = 0; b < nb; b++) begin
            if (f + 2 + b * Cpb < trtx[i].size()) v[b] = trtx[i][f + 2 + b * Cpb];
        end
        return v;
    endfunction

    function automatic int frame_len(input int i);
        int f;
        f = first_fall(i, 0);
        if (f < 0) return -1;
        for (int k = f; k < trdn[i].size(); k++) if (trdn[i][k]) return k - f + 1;
        return -1;
    endfunction

    function automatic int high_gap(input int i, input int flen);
        int f1, f2, run;
        f1 = first_fall(i, 0);
        if (f1 < 0) return -1;
        f2 = first_fall(i, f1 + flen);
        if (f2 < 0) return -1;
        run = 0;
        for (int k = f2 - 1; k >= 0 && trtx[i][k]; k--) run++;
        return run;
    endfunction

    function automatic int count_rd(input int i);
        int n = 0;
        foreach (trrd[i][k]) if (trrd[i][k]) n++;
        return n;
    endfunction

    function automatic int count_low(input int i);
        int n = 0;
        foreach (trtx[i][k]) if (!trtx[i][k]) n++;
        return n;
    endfunction

    task automatic push_all(input logic [7:0] w);
        for (int i = 0; i < NDut; i++) begin
            mem[i][wr_ptr[i] % FifoDepth] = w;
            wr_ptr[i]++;
            mq[i].push_back(w);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    logic [15:0] t1_bits [NDut] = '{16'h034A, 16'h054A, 16'h074A, 16'h074A};
    int          t1_nb   [NDut] = '{10, 11, 11, 11};
    int          t1_len  [NDut] = '{40, 44, 44, 44};

    initial begin
        rst   = 1'b0;
        tx_en = 1'b0;
        step(3);
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("reset_dut%0d", i),
                  32'({txl[i], rd[i], bsy[i], done[i], fcnt[i]}), 32'h80000);
        end
        rst = 1'b1;
        step(2);

        // Single 0xA5 frame on every variant.
        clear_traces();
        push_all(8'hA5);
        tx_en = 1'b1;
        step(70);
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("a5_bits_dut%0d", i), 32'(frame_bits(i, t1_nb[i])), 32'(t1_bits[i]));
            check($sformatf("a5_len_dut%0d", i), 32'(frame_len(i)), 32'(t1_len[i]));
            check($sformatf("a5_rd_dut%0d", i), 32'(count_rd(i)), 32'd1);
            check($sformatf("a5_count_dut%0d", i), 32'(fcnt[i]), 32'd1);
        end

        // Three queued words, back to back.
        clear_traces();
        push_all(8'h01);
        push_all(8'h02);
        push_all(8'h03);
        step(200);
        check("b2b_gap_dut3", 32'(high_gap(3, 44)), 32'd10);
        check("b2b_gap_dut0", 32'(high_gap(0, 40)), 32'd6);
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("b2b_rd_dut%0d", i), 32'(count_rd(i)), 32'd3);
            check($sformatf("b2b_count_dut%0d", i), 32'(fcnt[i]), 32'd4);
            check($sformatf("b2b_idle_dut%0d", i), 32'({bsy[i], fempty[i]}), 32'b01);
        end

        // Empty FIFO with permission held.
        clear_traces();
        step(100);
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("empty_rd_dut%0d", i), 32'(count_rd(i)), 32'd0);
            check($sformatf("empty_low_dut%0d", i), 32'(count_low(i)), 32'd0);
        end

        // Permission withdrawn during the data bits of 0x3C with two more words queued.
        clear_traces();
        push_all(8'h3C);
        push_all(8'h11);
        push_all(8'h22);
        step(14);
        tx_en = 1'b0;
        step(80);
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("hold_rd_dut%0d", i), 32'(count_rd(i)), 32'd1);
            check($sformatf("hold_count_dut%0d", i), 32'(fcnt[i]), 32'd5);
        end
        clear_traces();
        tx_en = 1'b1;
        step(150);
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("resume_rd_dut%0d", i), 32'(count_rd(i)), 32'd2);
            check($sformatf("resume_count_dut%0d", i), 32'(fcnt[i]), 32'd7);
        end

        // Reset during data bit 3; the next queued word goes out afterwards.
        push_all(8'h55);
        push_all(8'h66);
        step(20);
        #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("midrst_dut%0d", i), 32'({txl[i], bsy[i], fcnt[i]}), 32'h20000);
        end
        step(3);
        clear_traces();
        rst = 1'b1;
        step(60);
        check("post_rst_bits_dut0", 32'(frame_bits(0, 10)), 32'h2CC);
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("post_rst_rd_dut%0d", i), 32'(count_rd(i)), 32'd1);
            check($sformatf("post_rst_count_dut%0d", i), 32'(fcnt[i]), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
